// File: rtl/mips_instr_encoder.sv
// rtl/mips_instr_encoder.sv - MIPS field-to-word encoder writing sequential instruction memory.
// Optional beq/j delay-slot NOP padding under ENC_DELAY_SLOT_PAD_EN.
module mips_instr_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                DEPTH     = 256
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       restart,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 op_class,
  input  logic [1:0]                 op_sub,
  input  logic [4:0]                 rs,
  input  logic [4:0]                 rt,
  input  logic [4:0]                 rd,
  input  logic [4:0]                 shamt,
  input  logic [5:0]                 funct,
  input  logic [15:0]                imm,
  input  logic [25:0]                target,
  output logic                       imem_we,
  output logic [ADDR_W-1:0]          imem_addr,
  output logic [31:0]                imem_wdata,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       err_illegal
);

  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
`ifdef ENC_DELAY_SLOT_PAD_EN
  localparam logic [1:0] S_PAD   = 2'd2;
`endif
  localparam logic [1:0] S_FULL  = 2'd3;

  logic [1:0]  state;
  logic [31:0] enc_word;
  logic [5:0]  logic_op;
  logic        legal;
  logic        accept;
`ifdef ENC_DELAY_SLOT_PAD_EN
  logic        is_branch;
`endif

  assign in_ready = (state == S_IDLE) && !full;
  assign accept   = in_valid && in_ready && !restart;

  always_comb begin
    logic_op = 6'h0C;
    case (op_sub)
      2'b00:   logic_op = 6'h0C;
      2'b01:   logic_op = 6'h0D;
      2'b10:   logic_op = 6'h0E;
      default: logic_op = 6'h0A;
    endcase
  end

  always_comb begin
    enc_word = '0;
    legal    = 1'b1;
    case (op_class)
      3'b000:  enc_word = {6'h00, rs, rt, rd, shamt, funct};
      3'b001:  enc_word = {6'h23, rs, rt, imm};
      3'b010:  enc_word = {6'h2B, rs, rt, imm};
      3'b011:  enc_word = {6'h04, rs, rt, imm};
      3'b100:  enc_word = {6'h02, target};
      3'b101:  enc_word = {6'h08, rs, rt, imm};
      3'b110:  enc_word = {logic_op, rs, rt, imm};
      default: legal    = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      imem_we     <= 1'b0;
      imem_addr   <= BASE_ADDR;
      imem_wdata  <= '0;
      count       <= '0;
      full        <= 1'b0;
      err_illegal <= 1'b0;
`ifdef ENC_DELAY_SLOT_PAD_EN
      is_branch   <= 1'b0;
`endif
    end else if (restart) begin
      state       <= S_IDLE;
      imem_we     <= 1'b0;
      imem_addr   <= BASE_ADDR;
      count       <= '0;
      full        <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      imem_we     <= 1'b0;
      err_illegal <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (legal) begin
              state      <= S_WRITE;
              imem_we    <= 1'b1;
              imem_wdata <= enc_word;
`ifdef ENC_DELAY_SLOT_PAD_EN
              is_branch  <= (op_class == 3'b011) || (op_class == 3'b100);
`endif
            end else begin
              err_illegal <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          imem_addr <= imem_addr + ADDR_W'(4);
          count     <= count + CW'(1);
`ifdef ENC_DELAY_SLOT_PAD_EN
          // Pad is only worth issuing when a slot remains after this word.
          if (is_branch && (count < LAST)) begin
            state      <= S_PAD;
            imem_we    <= 1'b1;
            imem_wdata <= '0;
          end else if (count == LAST) begin
            state <= S_FULL;
            full  <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
`else
          if (count == LAST) begin
            state <= S_FULL;
            full  <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
`endif
        end
`ifdef ENC_DELAY_SLOT_PAD_EN
        S_PAD: begin
          imem_addr <= imem_addr + ADDR_W'(4);
          count     <= count + CW'(1);
          if (count == LAST) begin
            state <= S_FULL;
            full  <= 1'b1;
          end else begin
            state <= S_IDLE;
          end
        end
`endif
        S_FULL:  state <= S_FULL;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
